// File: rtl/daq_pkg.sv
// Shared definitions for the raw-hit DAQ packer: word width, marker and
// framing constants, and the packer state encoding.
package daq_pkg;

   localparam int DAQ_W = 19;

   localparam logic [DAQ_W-1:0] HDR0       = 19'h0DB0A;
   localparam logic [DAQ_W-1:0] TRL0       = 19'h0DE0D;
   localparam logic [DAQ_W-1:0] MRK_LYZERO = 19'h01000;
   localparam logic [DAQ_W-1:0] MRK_TBZERO = 19'h02000;
   localparam logic [DAQ_W-1:0] MRK_PAD    = 19'h03000;
   localparam logic [7:0]       FC_TAG     = 8'b0011_1010;

   // FETCH marks the first word of a bin, DATA the remaining words of it.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_FETCH = 3'd2,
      ST_DATA  = 3'd3,
      ST_PAD   = 3'd4,
      ST_TRL   = 3'd5
   } daq_state_e;

endpackage

// File: rtl/daq_crc22.sv
// CRC-22 (x^22 + x + 1, init 0) over 16 bits per cycle, MSB first.
// Only compiled when DAQ_RAW_PACKER_CRC_EN is defined; without it the
// packer emits zero CRC words and this block does not exist.
`ifdef DAQ_RAW_PACKER_CRC_EN
module daq_crc22 (
   input  logic        clk,
   input  logic        hard_rst,
   input  logic        clear,
   input  logic        en,
   input  logic [15:0] din,
   output logic [21:0] crc
);

   function automatic logic [21:0] crc_step(input logic [21:0] c, input logic [15:0] d);
      logic [21:0] r;
      logic        fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = r[21] ^ d[i];
         r  = {r[20:0], 1'b0};
         if (fb) r = r ^ 22'h000003;
      end
      return r;
   endfunction

   // Clear at frame start, fold in one 16-bit slice per enabled cycle.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst)  crc <= '0;
      else if (clear) crc <= '0;
      else if (en)    crc <= crc_step(crc, din);
   end

endmodule
`endif

// File: rtl/daq_raw_packer.sv
// Raw-hit DAQ packer: reads NLY x NWG hit snapshots from the raw ring memory
// and streams framed 19-bit DAQ words (header, optionally zero-suppressed
// data, 4-word alignment padding, trailer) over a valid/ready interface.
// Optional: define DAQ_RAW_PACKER_CRC_EN to fill the trailer CRC words.
module daq_raw_packer
   import daq_pkg::*;
#(
   parameter int NLY       = 6,
   parameter int NWG       = 48,
   parameter int MAX_TBINS = 32,
   parameter int TBW       = $clog2(MAX_TBINS + 1),
   parameter int ADDR_W    = 8
) (
   input  logic               clk,
   input  logic               hard_rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_addr,
   input  logic [TBW-1:0]     tbins,
   input  logic [11:0]        bxn,
   input  logic [11:0]        l1a_num,
   input  logic               zero_suppress,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [NLY*NWG-1:0] rd_data,
   output logic [DAQ_W-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done
);

   localparam int NCH = NWG / 12;
   localparam int LYW = (NLY > 1) ? $clog2(NLY) : 1;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef logic [NLY-1:0][NCH-1:0][11:0] bin_t;

   daq_state_e       state;
   logic [1:0]       sub;
   logic [LYW-1:0]   ly;
   logic [CHW-1:0]   ch;
   logic [TBW-1:0]   tb_eff_q, fetch_left, bins_left, tb_eff_in;
   logic [11:0]      bxn_q, l1a_q;
   logic             zs_q;
   logic [10:0]      wc;
   bin_t             cur, nxt;
   logic             cur_vld, nxt_vld, rd_vld;
   logic             last_q;
   logic [NLY-1:0]   lz;
   logic             bin_zero;
   logic             gen_valid, gen_last, bin_last, layer_last;
   logic [DAQ_W-1:0] gen_word, crc_w0, crc_w1;
   logic             accept, adv, gen_fire, consume, issue;
   logic [1:0]       occ;

   assign tb_eff_in = (tbins > TBW'(MAX_TBINS)) ? TBW'(MAX_TBINS) : tbins;
   assign accept    = start && !busy;
   assign adv       = !out_valid || out_ready;
   assign gen_fire  = adv && gen_valid;
   assign consume   = gen_fire && bin_last;
   assign done      = out_valid && out_ready && last_q;
   assign bin_zero  = (cur == '0);

   for (genvar k = 0; k < NLY; k++) begin : g_lz
      assign lz[k] = ~|cur[k];
   end

   // Keep at most two bins (cur + nxt) in flight counting the read on the bus.
   assign occ   = 2'(cur_vld) + 2'(nxt_vld) + 2'(rd_vld) - 2'(consume);
   assign issue = busy && (fetch_left != '0) && (occ < 2'd2);

`ifdef DAQ_RAW_PACKER_CRC_EN
   logic [21:0] crc;
   daq_crc22 u_crc (
      .clk      (clk),
      .hard_rst (hard_rst),
      .clear    (accept),
      .en       (gen_fire && (state != ST_TRL)),
      .din      (gen_word[15:0]),
      .crc      (crc)
   );
   assign crc_w0 = {8'h0, crc[10:0]};
   assign crc_w1 = {8'h0, crc[21:11]};
`else
   assign crc_w0 = '0;
   assign crc_w1 = '0;
`endif

   // Next word to offer, derived from the state and the current bin.
   always_comb begin
      gen_valid  = 1'b0;
      gen_word   = '0;
      gen_last   = 1'b0;
      bin_last   = 1'b0;
      layer_last = 1'b0;
      case (state)
         ST_HDR: begin
            gen_valid = 1'b1;
            case (sub)
               2'd0:    gen_word = HDR0;
               2'd1:    gen_word = {7'h0D, bxn_q};
               2'd2:    gen_word = {7'h0D, l1a_q};
               default: gen_word = {3'b0, zs_q, 9'h0, 6'(tb_eff_q)};
            endcase
         end
         ST_FETCH, ST_DATA: begin
            gen_valid = cur_vld;
            if (zs_q && bin_zero) begin
               gen_word = MRK_TBZERO;
               bin_last = 1'b1;
            end else if (zs_q && lz[ly]) begin
               gen_word   = MRK_LYZERO;
               layer_last = 1'b1;
            end else begin
               gen_word   = {7'b0, cur[ly][ch]};
               layer_last = (ch == CHW'(NCH - 1));
            end
            if (layer_last && (ly == LYW'(NLY - 1))) bin_last = 1'b1;
         end
         // An aligned count emits the trailer marker straight from PAD.
         ST_PAD: begin
            gen_valid = 1'b1;
            gen_word  = (wc[1:0] != 2'd0) ? MRK_PAD : TRL0;
         end
         ST_TRL: begin
            gen_valid = 1'b1;
            case (sub)
               2'd1:    gen_word = crc_w0;
               2'd2:    gen_word = crc_w1;
               default: gen_word = {FC_TAG, wc};
            endcase
            gen_last = (sub == 2'd3);
         end
         default: ;
      endcase
   end

   // Frame sequencing; wc counts words handed to the output register.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         state     <= ST_IDLE;
         sub       <= '0;
         ly        <= '0;
         ch        <= '0;
         wc        <= '0;
         busy      <= 1'b0;
         tb_eff_q  <= '0;
         bins_left <= '0;
         bxn_q     <= '0;
         l1a_q     <= '0;
         zs_q      <= 1'b0;
      end else begin
         if (accept) begin
            state     <= ST_HDR;
            sub       <= '0;
            ly        <= '0;
            ch        <= '0;
            wc        <= '0;
            busy      <= 1'b1;
            tb_eff_q  <= tb_eff_in;
            bins_left <= tb_eff_in;
            bxn_q     <= bxn;
            l1a_q     <= l1a_num;
            zs_q      <= zero_suppress;
         end else if (gen_fire) begin
            wc <= wc + 11'd1;
            case (state)
               ST_HDR: begin
                  sub <= sub + 2'd1;
                  if (sub == 2'd3) state <= (tb_eff_q == '0) ? ST_PAD : ST_FETCH;
               end
               ST_FETCH, ST_DATA: begin
                  if (bin_last) begin
                     ly        <= '0;
                     ch        <= '0;
                     bins_left <= bins_left - 1'b1;
                     state     <= (bins_left == TBW'(1)) ? ST_PAD : ST_FETCH;
                  end else if (layer_last) begin
                     ly    <= ly + 1'b1;
                     ch    <= '0;
                     state <= ST_DATA;
                  end else begin
                     ch    <= ch + 1'b1;
                     state <= ST_DATA;
                  end
               end
               ST_PAD: begin
                  if (wc[1:0] == 2'd0) begin
                     state <= ST_TRL;
                     sub   <= 2'd1;
                  end
               end
               ST_TRL: begin
                  sub <= sub + 2'd1;
                  if (sub == 2'd3) state <= ST_IDLE;
               end
               default: ;
            endcase
         end
         if (done) busy <= 1'b0;
      end
   end

   // Bin prefetch: rd_data returns one cycle after issue into cur or nxt.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         rd_addr    <= '0;
         fetch_left <= '0;
         rd_vld     <= 1'b0;
         cur        <= '0;
         nxt        <= '0;
         cur_vld    <= 1'b0;
         nxt_vld    <= 1'b0;
      end else if (accept) begin
         rd_addr    <= start_addr;
         fetch_left <= tb_eff_in;
         rd_vld     <= 1'b0;
         cur_vld    <= 1'b0;
         nxt_vld    <= 1'b0;
      end else begin
         if (issue) begin
            rd_addr    <= rd_addr + 1'b1;
            fetch_left <= fetch_left - 1'b1;
         end
         rd_vld <= issue;
         if (!cur_vld || consume) begin
            if (nxt_vld) begin
               cur     <= nxt;
               cur_vld <= 1'b1;
               nxt     <= rd_data;
               nxt_vld <= rd_vld;
            end else begin
               cur     <= rd_data;
               cur_vld <= rd_vld;
            end
         end else if (rd_vld) begin
            nxt     <= rd_data;
            nxt_vld <= 1'b1;
         end
      end
   end

   // Output register; holds while the consumer stalls.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         last_q    <= 1'b0;
      end else if (adv) begin
         out_valid <= gen_valid;
         last_q    <= gen_valid && gen_last;
         if (gen_valid) out_data <= gen_word;
      end
   end

endmodule
